// File: rtl/ladner64_mp_add_seq.sv
// Multi-word add/subtract sequencer wrapped around an external 64-bit
// combinational adder. Operand words arrive LSW first, one per beat.
// For each accepted beat the sequencer picks the adder carry-in and the
// B inversion, then registers the sum word with its beat index, the
// carry-out, and the signed overflow. Latency is one cycle, and
// throughput is one beat per cycle.
module ladner64_mp_add_seq #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic             in_first,
    input  logic             in_last,
    output logic [63:0]      add_a,
    output logic [63:0]      add_b,
    output logic             add_cin,
    input  logic [63:0]      add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_s,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             err_restart
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CHAIN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             valid_q, valid_d;
    logic [63:0]      s_q, s_d;
    logic [IDX_W-1:0] idx_q, idx_d;   // doubles as the beat counter
    logic             last_q, last_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic accept;
    logic eff_first;
    logic esub;

    // The output register is free when it is empty or being drained this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    // A beat with no open op starts a new op even when in_first is not set.
    assign eff_first = in_first || (state_q == S_IDLE);
    assign esub      = eff_first ? in_sub : sub_q;

    // Drive the adder. Subtract is A + ~B + 1, and the +1 enters only on the first word.
    always_comb begin
        add_a   = in_a;
        add_b   = esub ? ~in_b : in_b;
        add_cin = eff_first ? (in_sub | in_cin) : carry_q;
    end

    // Next state: load the result on accept, otherwise let a drain clear valid.
    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        valid_d = valid_q;
        s_d     = s_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            s_d     = add_s;
            cout_d  = add_cout;
            carry_d = add_cout;
            last_d  = in_last;
            idx_d   = eff_first ? '0 : idx_q + IDX_W'(1);
            ovf_d   = in_last & (add_a[63] == add_b[63]) & (add_s[63] != add_a[63]);
            if (eff_first)
                sub_d = in_sub;
            // An in_first beat that lands on an open chain abandons that chain.
            if (in_first && (state_q == S_CHAIN))
                err_d = 1'b1;
            state_d = in_last ? S_IDLE : S_CHAIN;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers. Reset discards any partial op at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            valid_q <= 1'b0;
            s_q     <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            valid_q <= valid_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_s       = s_q;
    assign out_idx     = idx_q;
    assign out_last    = last_q;
    assign out_cout    = cout_q;
    assign out_ovf     = ovf_q;
    assign err_restart = err_q;

endmodule

// File: tb/tb_ladner64_mp_add_seq.sv
// Bench for ladner64_mp_add_seq. A behavioural 64-bit adder stands in for
// the real adder. A table of directed beats is applied with out_ready held
// high. Short hand-written sequences then cover backpressure, restart,
// and a mid-op asynchronous reset.
module tb_ladner64_mp_add_seq;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [63:0] in_a, in_b;
    logic        in_cin, in_sub, in_first, in_last;
    logic [63:0] add_a, add_b, add_s;
    logic        add_cin, add_cout;
    logic        out_valid, out_ready;
    logic [63:0] out_s;
    logic [3:0]  out_idx;
    logic        out_last, out_cout, out_ovf, err_restart;

    int checks = 0;
    int passed = 0;

    ladner64_mp_add_seq #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .in_first(in_first), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_idx(out_idx), .out_last(out_last),
        .out_cout(out_cout), .out_ovf(out_ovf), .err_restart(err_restart)
    );

    // Stand-in for the external combinational adder.
    logic [64:0] sum65;
    assign sum65    = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};
    assign add_s    = sum65[63:0];
    assign add_cout = sum65[64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] a, b;
        logic        cin, sub, first, last;
        logic        e_cin;
        logic [63:0] e_s;
        logic        e_cout;
        logic [3:0]  e_idx;
        logic        e_last, e_ovf;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(string n, logic [63:0] a, logic [63:0] b,
                                logic cin, logic sub, logic first, logic last,
                                logic e_cin, logic [63:0] e_s, logic e_cout,
                                logic [3:0] e_idx, logic e_last, logic e_ovf);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.first = first; v.last = last; v.e_cin = e_cin; v.e_s = e_s;
        v.e_cout = e_cout; v.e_idx = e_idx; v.e_last = e_last; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, input logic first, input logic last);
        in_valid = v; in_a = a; in_b = b; in_cin = cin;
        in_sub = sub; in_first = first; in_last = last;
    endtask

    initial begin
        vecs[0]  = mk("single_add",  64'd1, 64'd1, 1, 0, 1, 1,  1, 64'd3, 0, 0, 1, 0);
        vecs[1]  = mk("add128_b0",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1, 0,
                      0, 64'd0, 1, 0, 0, 0);
        vecs[2]  = mk("add128_b1",   64'd0, 64'd0, 0, 0, 0, 1,  1, 64'd1, 0, 1, 1, 0);
        vecs[3]  = mk("sub_ovf",     64'h8000_0000_0000_0000, 64'd1, 0, 1, 1, 1,
                      1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 1, 1);
        vecs[4]  = mk("sub192_b0",   64'd0, 64'd1, 0, 1, 1, 0,
                      1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        // in_sub is low on later beats; the held sub register must keep subtracting.
        vecs[5]  = mk("sub192_b1",   64'd0, 64'd0, 0, 0, 0, 0,
                      0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0);
        vecs[6]  = mk("sub192_b2",   64'd0, 64'd0, 0, 0, 0, 1,
                      0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2, 1, 0);
        vecs[7]  = mk("add_ovf",     64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1, 1,
                      0, 64'h8000_0000_0000_0000, 0, 0, 1, 1);
        vecs[8]  = mk("idle_nofirst", 64'd5, 64'd6, 1, 0, 0, 1, 1, 64'd12, 0, 0, 1, 0);
        vecs[9]  = mk("ovf_notlast", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1, 0,
                      0, 64'h8000_0000_0000_0000, 0, 0, 0, 0);
        // in_cin=1 on a later beat must be ignored (the chain carry is 0).
        vecs[10] = mk("chain_cin",   64'd0, 64'd0, 1, 0, 0, 1,  0, 64'd0, 0, 1, 1, 0);

        rst = 1'b0; out_ready = 1'b1;
        drive(0, 64'd0, 64'd0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_s", out_s, 64'd0);
        chk("rst_idx", {60'd0, out_idx}, 64'd0);
        chk("rst_flags", {60'd0, out_last, out_cout, out_ovf, err_restart}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        step();

        // Directed table, one beat per cycle with no backpressure.
        for (int i = 0; i < 11; i++) begin
            drive(1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].first, vecs[i].last);
            #1;
            chk({vecs[i].name, "_cin"}, {63'd0, add_cin}, {63'd0, vecs[i].e_cin});
            step();
            chk({vecs[i].name, "_valid"}, {63'd0, out_valid}, 64'd1);
            chk({vecs[i].name, "_s"}, out_s, vecs[i].e_s);
            chk({vecs[i].name, "_cout"}, {63'd0, out_cout}, {63'd0, vecs[i].e_cout});
            chk({vecs[i].name, "_idx"}, {60'd0, out_idx}, {60'd0, vecs[i].e_idx});
            chk({vecs[i].name, "_last"}, {63'd0, out_last}, {63'd0, vecs[i].e_last});
            chk({vecs[i].name, "_ovf"}, {63'd0, out_ovf}, {63'd0, vecs[i].e_ovf});
        end
        chk("no_err_yet", {63'd0, err_restart}, 64'd0);

        // Output-only advance drains the register.
        drive(0, 64'd0, 64'd0, 0, 0, 0, 0);
        step();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure across three beats.
        out_ready = 1'b0;
        drive(1, 64'd10, 64'd1, 0, 0, 1, 0);
        step();
        chk("bp_b0_s", out_s, 64'd11);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        drive(1, 64'd20, 64'd2, 0, 0, 0, 0);
        step();
        chk("bp_hold1_s", out_s, 64'd11);
        chk("bp_hold1_idx", {60'd0, out_idx}, 64'd0);
        step();
        chk("bp_hold2_s", out_s, 64'd11);
        chk("bp_hold2_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", {63'd0, in_ready}, 64'd1);
        step();
        chk("bp_b1_s", out_s, 64'd22);
        chk("bp_b1_idx", {60'd0, out_idx}, 64'd1);
        drive(1, 64'd30, 64'd3, 0, 0, 0, 1);
        step();
        chk("bp_b2_s", out_s, 64'd33);
        chk("bp_b2_idx", {60'd0, out_idx}, 64'd2);
        chk("bp_b2_last", {63'd0, out_last}, 64'd1);
        drive(0, 64'd0, 64'd0, 0, 0, 0, 0);
        step();
        chk("bp_drain", {63'd0, out_valid}, 64'd0);

        // Restart: in_first while a chain is open.
        drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1, 0);
        step();
        chk("rs_a_s", out_s, 64'd0);
        chk("rs_a_err", {63'd0, err_restart}, 64'd0);
        drive(1, 64'd3, 64'd4, 0, 0, 1, 1);
        #1;
        chk("rs_b_cin", {63'd0, add_cin}, 64'd0);
        step();
        chk("rs_b_s", out_s, 64'd7);
        chk("rs_b_idx", {60'd0, out_idx}, 64'd0);
        chk("rs_b_err", {63'd0, err_restart}, 64'd1);
        drive(0, 64'd0, 64'd0, 0, 0, 0, 0);
        repeat (3) step();
        chk("rs_err_sticky", {63'd0, err_restart}, 64'd1);

        // Async reset in the middle of a three-beat op.
        drive(1, 64'd1, 64'd2, 0, 0, 1, 0);
        step();
        chk("ar_b0_s", out_s, 64'd3);
        drive(1, 64'd0, 64'd0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_s", out_s, 64'd0);
        chk("ar_err", {63'd0, err_restart}, 64'd0);
        chk("ar_idx", {60'd0, out_idx}, 64'd0);
        #1 rst = 1'b0;
        drive(1, 64'd5, 64'd5, 1, 0, 0, 0);
        #1;
        chk("ar_post_cin", {63'd0, add_cin}, 64'd1);
        step();
        chk("ar_post_s", out_s, 64'd11);
        chk("ar_post_idx", {60'd0, out_idx}, 64'd0);
        drive(0, 64'd0, 64'd0, 0, 0, 0, 0);
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
